// File: rtl/lsu_bus_if.sv
// Purpose: load/store bus master for the memory stage; one access outstanding, raw 32-bit read word returned.
// Latency: request issued combinationally in the access cycle; minimum 2 stall cycles (grant in cycle 0, rvalid in cycle 1).
// Backpressure: holds the pipeline via stall_mem_o until the response arrives; waits in REQ for bus_gnt_i, in DONE for stall_m_i.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   alu_result_m_i                 byte address of the memory-stage access
//   write_data_m_i                 right-aligned store data
//   width_src_m_i                  [1:0] 00 word, 01 half, 10 byte, 11 word; [2] unsigned flag (unused here)
//   mem_write_m_i, mem_read_m_i    access type (both set = store)
//   stall_m_i                      memory-stage stall from hazard unit
//   read_data_m_o                  registered raw read word
//   stall_mem_o, misaligned_o      stall request / misaligned access flag
//   bus_req_o .. bus_be_o          request channel to data bus
//   bus_gnt_i, bus_rvalid_i, bus_rdata_i  grant and response from data bus
module lsu_bus_if (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] alu_result_m_i,
  input  logic [31:0] write_data_m_i,
  input  logic [2:0]  width_src_m_i,
  input  logic        mem_write_m_i,
  input  logic        mem_read_m_i,
  input  logic        stall_m_i,
  output logic [31:0] read_data_m_o,
  output logic        stall_mem_o,
  output logic        misaligned_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic is_half, is_byte;
  logic access, misaligned, start;
  logic is_load_q, capture;

  // Sign/zero extension happens downstream, so the unsigned flag is not needed.
  logic unused_width_flag;
  assign unused_width_flag = width_src_m_i[2];

  assign is_half = (width_src_m_i[1:0] == 2'b01);
  assign is_byte = (width_src_m_i[1:0] == 2'b10);
  assign access  = mem_read_m_i | mem_write_m_i;

  // Encoding 11 falls through to word, so word alignment applies to it too.
  assign misaligned = is_half ? alu_result_m_i[0]
                    : is_byte ? 1'b0
                    : (alu_result_m_i[1:0] != 2'b00);

  assign start = (state_q == IDLE) && access && !misaligned;

  // Request payload is driven straight from the memory-stage inputs; the
  // pipeline stall keeps them stable for the whole request phase.
  assign bus_we_o   = mem_write_m_i;
  assign bus_addr_o = {alu_result_m_i[31:2], 2'b00};

  always_comb begin
    bus_wdata_o = write_data_m_i;
    bus_be_o    = 4'b1111;
    if (is_half) begin
      bus_wdata_o = {2{write_data_m_i[15:0]}};
    end else if (is_byte) begin
      bus_wdata_o = {4{write_data_m_i[7:0]}};
    end
    if (mem_write_m_i) begin
      if (is_half) begin
        bus_be_o = alu_result_m_i[1] ? 4'b1100 : 4'b0011;
      end else if (is_byte) begin
        bus_be_o = 4'b0001 << alu_result_m_i[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_req_o    = 1'b0;
    stall_mem_o  = 1'b0;
    misaligned_o = 1'b0;
    capture      = 1'b0;
    case (state_q)
      IDLE: begin
        misaligned_o = access & misaligned;
        if (start) begin
          bus_req_o   = 1'b1;
          stall_mem_o = 1'b1;
          state_d     = bus_gnt_i ? WAIT : REQ;
        end
      end
      REQ: begin
        bus_req_o   = 1'b1;
        stall_mem_o = 1'b1;
        if (bus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        stall_mem_o = 1'b1;
        if (bus_rvalid_i) begin
          capture = is_load_q;
          state_d = DONE;
        end
      end
      DONE: begin
        // stall_mem_o stays low here so stall_m_i never loops back to it.
        if (!stall_m_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      read_data_m_o <= 32'd0;
      is_load_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      // Remember the access type at launch; stores must not touch read data.
      if (start) is_load_q <= ~mem_write_m_i;
      if (capture) read_data_m_o <= bus_rdata_i;
    end
  end

endmodule

// File: doc/lsu_bus_if.md
# lsu_bus_if

Load/store bus interface between the memory stage of the pipelined RISC-V core and a single-port, variable-latency data bus. Takes the memory-stage address, store data, width and access type, and runs a request/grant/response transaction with one access outstanding. Holds the pipeline via a stall request until the access completes, then returns the raw 32-bit read word. The memory stage performs load width reduction and sign extension.

## Interface
- No parameters.
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- alu_result_m_i  in  32  byte address of the memory-stage access
- write_data_m_i  in  32  store data, right-aligned
- width_src_m_i  in  3  [1:0]: 00 word, 01 half, 10 byte, 11 treated as word; [2] unsigned flag, ignored here
- mem_write_m_i  in  1  store in memory stage
- mem_read_m_i  in  1  load in memory stage
- stall_m_i  in  1  memory-stage stall from hazard unit (all causes)
- read_data_m_o  out  32  raw read word to memory stage, registered
- stall_mem_o  out  1  stall request to hazard unit
- misaligned_o  out  1  misaligned access detected
- bus_req_o  out  1  bus request
- bus_we_o  out  1  1 = write
- bus_addr_o  out  32  word address: {alu_result_m_i[31:2], 2'b00}
- bus_wdata_o  out  32  lane-replicated store data
- bus_be_o  out  4  byte enables
- bus_gnt_i  in  1  request accepted this cycle
- bus_rvalid_i  in  1  response valid (loads and stores)
- bus_rdata_i  in  32  read data, valid with bus_rvalid_i

## Operation
- access = (mem_read_m_i | mem_write_m_i); on both set, the access is treated as a store.
- Misaligned cases: word with addr[1:0] ≠ 0, half with addr[0] ≠ 0.
  - misaligned_o = access & misaligned, in IDLE only.
  - No bus request and no stall for a misaligned access.
- Store data: word passes unchanged. Half is {2{wdata[15:0]}}. Byte is {4{wdata[7:0]}}.
- Store byte enables:
  - Word: 1111.
  - Half: 0011 when addr[1] = 0, 1100 when addr[1] = 1.
  - Byte: 0001 << addr[1:0].
- Loads drive bus_be_o = 1111. bus_wdata_o is don't-care for loads.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE:
    - If access & ~misaligned: bus_req_o = 1 and stall_mem_o = 1 in the same cycle (combinational from inputs).
    - If bus_gnt_i, go to WAIT; otherwise go to REQ.
  - REQ: bus_req_o = 1, stall_mem_o = 1. Go to WAIT on bus_gnt_i.
  - WAIT: bus_req_o = 0, stall_mem_o = 1. On bus_rvalid_i, latch bus_rdata_i into read_data_m_o (loads only) and go to DONE.
  - DONE: bus_req_o = 0, stall_mem_o = 0. Go to IDLE when stall_m_i = 0; otherwise stay in DONE.
- Request stability: while bus_req_o = 1, bus_we_o, bus_addr_o, bus_wdata_o and bus_be_o are stable. These are guaranteed by the pipeline stall.
- bus_rvalid_i in IDLE or REQ is ignored.
- bus_rvalid_i in the same cycle as the grant (IDLE/REQ) is illegal from the bus and not supported.
- Stores leave read_data_m_o unchanged.

## Timing
- Reset values: state = IDLE, read_data_m_o = 0.
  - With no access present: bus_req_o = 0, stall_mem_o = 0, misaligned_o = 0.
- Reset mid-transaction: return to IDLE next edge and drop bus_req_o. A later stray bus_rvalid_i is ignored.
- Minimum latency (grant in the request cycle, rvalid one cycle later):
  - Cycle 0: IDLE request.
  - Cycle 1: WAIT, rvalid.
  - Cycle 2: DONE, no stall.
  - The instruction leaves the memory stage at the end of cycle 2, giving 2 stall cycles.
- Each grant-wait cycle adds one cycle. Each response-wait cycle adds one cycle.
- read_data_m_o is valid from the DONE cycle until the next load's rvalid edge.
- A new access back-to-back after DONE starts in IDLE on the following cycle.
- No combinational path from stall_m_i to stall_mem_o (stall_mem_o = 0 in DONE).

## Test plan
- Aligned load: addr 0x0000_1004, grant immediate, rvalid one cycle later with 0xDEADBEEF.
  - Required: bus_addr_o = 0x0000_1004, bus_be_o = 1111, stall_mem_o high exactly 2 cycles, read_data_m_o = 0xDEADBEEF in DONE.
- Byte store: addr 0x0000_2003, data 0x0000_00A5, grant delayed 3 cycles.
  - Required: bus_be_o = 1000, bus_wdata_o = 0xA5A5A5A5, bus_addr_o = 0x0000_2000, bus_req_o held 4 cycles with stable signals, read_data_m_o unchanged.
- Half store at addr 0x…2: be = 1100, wdata = {2{data[15:0]}}.
- Misaligned half at addr 0x…1 and word at 0x…2:
  - Required: misaligned_o = 1, bus_req_o = 0, stall_mem_o = 0.
- DONE with stall_m_i = 1 for 2 cycles: FSM stays in DONE, stall_mem_o = 0, no new request; returns to IDLE when stall_m_i drops.
- reset_i asserted in WAIT, then rvalid arrives: state goes to IDLE, read_data_m_o = 0, stray rvalid ignored, next load completes normally.
